ram_reader: RTL and testbench

RAM_READER -- requirements
Module: ram_reader

---
 rtl/ram_reader_pkg.sv | 50 +++++
 rtl/ram_reader_hex7seg.sv | 13 +
 rtl/ram_reader.sv | 103 ++++++++++
 tb/tb_ram_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM scan reader: FSM state encoding and
// active-low seven-segment glyphs (segment order gfedcba).
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic logic [6:0] seg_glyph(input logic [3:0] value);
    case (value)
      4'h0:    seg_glyph = SEG_0;
      4'h1:    seg_glyph = SEG_1;
      4'h2:    seg_glyph = SEG_2;
      4'h3:    seg_glyph = SEG_3;
      4'h4:    seg_glyph = SEG_4;
      4'h5:    seg_glyph = SEG_5;
      4'h6:    seg_glyph = SEG_6;
      4'h7:    seg_glyph = SEG_7;
      4'h8:    seg_glyph = SEG_8;
      4'h9:    seg_glyph = SEG_9;
      4'hA:    seg_glyph = SEG_A;
      4'hB:    seg_glyph = SEG_B;
      4'hC:    seg_glyph = SEG_C;
      4'hD:    seg_glyph = SEG_D;
      4'hE:    seg_glyph = SEG_E;
      default: seg_glyph = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/ram_reader_hex7seg.sv
// Hex digit to active-low seven-segment decoder.
module hex7seg
  import ram_reader_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_glyph(value);
  end

endmodule

// File: rtl/ram_reader.sv
// Scans a RAM word by word, holding each captured word on LEDR for TICK_DIV
// cycles; single-pass or continuous, with the address shown on HEX0.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int NBits    = 7,
  parameter int NAddr    = 3,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic             MAX10_CLK1_50,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             rd_en,
  output logic [NAddr-1:0] rd_addr,
  input  logic [NBits-1:0] rd_data,
  output logic [NBits-1:0] LEDR,
  output logic [6:0]       HEX0,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(TICK_DIV - 1);
  localparam logic [NAddr-1:0] ADDR_LAST = '1;

  state_t          state;
  state_t          next_state;
  logic            start_q;
  logic            armed;
  logic            start_edge;
  logic [CW-1:0]   hold_cnt;
  logic            hold_last;
  logic            pass_continues;

  // armed stays low for the first clock after reset so a start level that is
  // already high at release is not mistaken for an edge.
  assign start_edge     = start & ~start_q & armed;
  assign hold_last      = (hold_cnt == HOLD_LAST);
  assign pass_continues = (rd_addr != ADDR_LAST) || mode;

  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_edge) next_state = READ;
      READ:    next_state = CAPTURE;
      CAPTURE: next_state = HOLD;
      HOLD:    if (hold_last) next_state = pass_continues ? READ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == READ);
    busy  = (state != IDLE);
    done  = (state == HOLD) && hold_last && (rd_addr == ADDR_LAST) && !mode;
  end

  // Address increment wraps naturally from ADDR_LAST to zero in loop mode.
  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      start_q  <= 1'b0;
      armed    <= 1'b0;
      rd_addr  <= '0;
      LEDR     <= '0;
      hold_cnt <= '0;
    end else begin
      start_q <= start;
      armed   <= 1'b1;
      case (state)
        IDLE: begin
          if (start_edge) rd_addr <= '0;
        end
        CAPTURE: begin
          LEDR     <= rd_data;
          hold_cnt <= '0;
        end
        HOLD: begin
          if (!hold_last) begin
            hold_cnt <= hold_cnt + CW'(1);
          end else if (pass_continues) begin
            rd_addr <= rd_addr + NAddr'(1);
          end
        end
        default: ;
      endcase
    end
  end

  hex7seg u_hex0 (
    .value (4'(rd_addr)),
    .seg   (HEX0)
  );

endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader with TICK_DIV=4 and RAM[a]=3*a+1.
module tb_ram_reader;

  localparam int NBITS  = 7;
  localparam int NADDR  = 3;
  localparam int TDIV   = 4;
  localparam int PERIOD = TDIV + 2;
  localparam int LAST   = (1 << NADDR) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic             rd_en;
  logic [NADDR-1:0] rd_addr;
  logic [NBITS-1:0] rd_data = '0;
  logic [NBITS-1:0] LEDR;
  logic [6:0]       HEX0;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rden_cnt = 0;
  int captured[$];
  logic rden_d1 = 1'b0;
  logic rden_d2 = 1'b0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int expect_words [8] = '{1, 4, 7, 10, 13, 16, 19, 22};

  ram_reader #(.NBits(NBITS), .NAddr(NADDR), .TICK_DIV(TDIV)) dut (
    .MAX10_CLK1_50 (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .LEDR          (LEDR),
    .HEX0          (HEX0),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic int ram(input int a);
    return (3 * a + 1) & 8'h7F;
  endfunction

  // RAM: data valid only in the cycle after rd_en, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? NBITS'(ram(int'(rd_addr))) : 7'h55;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a scan is a timeline of PERIOD-cycle word slots.
  bit m_busy = 0;
  int m_t = 0;
  int m_addr = 0;
  int m_led = 0;
  bit m_prev = 0;
  bit m_seen = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_t <= 0; m_addr <= 0; m_led <= 0; m_prev <= 0; m_seen <= 0;
    end else begin
      m_prev <= start;
      m_seen <= 1;
      if (!m_busy) begin
        if (m_seen && start && !m_prev) begin
          m_busy <= 1; m_t <= 0; m_addr <= 0;
        end
      end else begin
        if (m_t == 1) m_led <= ram(m_addr);
        if (m_t == PERIOD - 1) begin
          m_t <= 0;
          if (m_addr < LAST) m_addr <= m_addr + 1;
          else if (mode) m_addr <= 0;
          else m_busy <= 0;
        end else begin
          m_t <= m_t + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("rd_en", int'(rd_en), int'(m_busy && m_t == 0));
    check("busy", int'(busy), int'(m_busy));
    check("rd_addr", int'(rd_addr), m_addr);
    check("LEDR", int'(LEDR), m_led);
    check("HEX0", int'(HEX0), int'(glyph[m_addr]));
    check("done", int'(done), int'(m_busy && m_t == PERIOD - 1 && m_addr == LAST && !mode));
    if (done) done_cnt++;
    if (rd_en) rden_cnt++;
    if (rden_d2) captured.push_back(int'(LEDR));
    rden_d2 <= rden_d1;
    rden_d1 <= rd_en;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    rden_cnt = 0;
    captured.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      cyc(1);
      n++;
    end
    if (!done) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    // Reset held with start high; release must not trigger a scan.
    start = 1'b1;
    cyc(3);
    check("rst_LEDR", int'(LEDR), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_HEX0", int'(HEX0), 'h40);
    rst = 1'b1;
    cyc(5);
    check("start_at_release_busy", int'(busy), 0);
    check("start_at_release_rden", rden_cnt, 0);
    start = 1'b0;
    cyc(2);

    // Single pass with latency probe.
    clear_counts();
    mode = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    check("latency_2cyc_LEDR", int'(LEDR), 0);
    cyc(1);
    check("latency_3cyc_LEDR", int'(LEDR), 1);
    wait_done("single", 200);
    cyc(3);
    check("single_done_cnt", done_cnt, 1);
    check("single_rden_cnt", rden_cnt, 8);
    check("single_busy", int'(busy), 0);
    check("single_rd_addr", int'(rd_addr), 7);
    check("single_LEDR", int'(LEDR), 22);
    check("single_words", int'(captured.size()), 8);
    foreach (expect_words[i])
      if (i < captured.size()) check("single_word", captured[i], expect_words[i]);

    // Start held high for 100 cycles: one pass only.
    clear_counts();
    start = 1'b1;
    cyc(100);
    start = 1'b0;
    cyc(5);
    check("held_rden_cnt", rden_cnt, 8);
    check("held_done_cnt", done_cnt, 1);

    // Second start edge while busy is ignored.
    clear_counts();
    pulse_start();
    cyc(10);
    pulse_start();
    wait_done("busy_edge", 200);
    cyc(20);
    check("busy_edge_rden_cnt", rden_cnt, 8);
    check("busy_edge_done_cnt", done_cnt, 1);
    check("busy_edge_busy", int'(busy), 0);

    // Continuous loop, then drop to single pass mid-scan.
    clear_counts();
    mode = 1'b1;
    pulse_start();
    cyc(60);
    check("loop_done_cnt", done_cnt, 0);
    check("loop_busy", int'(busy), 1);
    check("loop_words_ge9", int'(captured.size() >= 9), 1);
    if (captured.size() >= 9) check("loop_wrap_word0", captured[8], 1);
    mode = 1'b0;
    wait_done("loop_stop", 100);
    cyc(3);
    check("loop_stop_done_cnt", done_cnt, 1);
    check("loop_stop_rden_cnt", rden_cnt, 16);
    check("loop_stop_busy", int'(busy), 0);

    // Reset mid-scan in HOLD at address 3.
    clear_counts();
    pulse_start();
    begin
      int n = 0;
      while (LEDR != 7'd10 && n < 100) begin
        cyc(1);
        n++;
      end
    end
    check("pre_rst_rd_addr", int'(rd_addr), 3);
    rst = 1'b0;
    #1;
    check("midrst_LEDR", int'(LEDR), 0);
    check("midrst_rd_addr", int'(rd_addr), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_HEX0", int'(HEX0), 'h40);
    check("midrst_rd_en", int'(rd_en), 0);
    cyc(2);
    rst = 1'b1;
    clear_counts();
    cyc(30);
    check("post_rst_rden_cnt", rden_cnt, 0);
    check("post_rst_busy", int'(busy), 0);
    pulse_start();
    wait_done("post_rst", 200);
    cyc(3);
    check("post_rst_pass_rden", rden_cnt, 8);
    check("post_rst_LEDR", int'(LEDR), 22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
